// File: rtl/hello_nioii_nios2_mul_seq.sv
// Sequencer for the Nios II 3-partial-product 16x16 multiplier cell: 32x32 unsigned multiply,
// low word by default, high word (mulxuu) as well when MUL_SEQ_HIGH_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EXEC1 | lo*lo/lo*hi/hi*lo pass in the cell, cell_en high for CELL_LATENCY cycles
// COMB1 | combine p1/p2/p3 into the low word (or keep mid/carry for the high word)
// EXEC2 | hi*hi pass in the cell, cell_en high for CELL_LATENCY cycles
// COMB2 | hi*hi + mid[32:16] + carry -> high word
// RESP  | rsp_valid high, result held until the consumer takes it
module hello_nioii_nios2_mul_seq #(
   parameter int CELL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        req_high,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        busy,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC1,
      S_COMB1,
      S_EXEC2,
      S_COMB2,
      S_RESP
   } state_t;

   localparam logic [1:0] LAT_M1 = 2'(CELL_LATENCY - 1);

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic [32:0] w_mid;
   logic [32:0] w_lo;

   assign w_mid = {1'b0, cell_p2} + {1'b0, cell_p3};
   assign w_lo  = {1'b0, cell_p1} + {1'b0, w_mid[15:0], 16'h0000};

`ifdef MUL_SEQ_HIGH_EN
   logic        r_high;
   logic [16:0] r_mid_hi;
   logic        r_carry;
`else
   logic w_unused;
   assign w_unused = ^{req_high, w_mid[32:16], w_lo[32]};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 2'd0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= 32'h0;
         busy       <= 1'b0;
         cell_en    <= 1'b0;
         cell_src1  <= 32'h0;
         cell_src2  <= 32'h0;
`ifdef MUL_SEQ_HIGH_EN
         r_high     <= 1'b0;
         r_mid_hi   <= 17'h0;
         r_carry    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  // cell_src* double as the operand latches for the whole operation
                  cell_src1 <= req_src1;
                  cell_src2 <= req_src2;
                  cell_en   <= 1'b1;
                  r_cnt     <= LAT_M1;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef MUL_SEQ_HIGH_EN
                  r_high    <= req_high;
`endif
                  r_state   <= S_EXEC1;
               end
            end
            S_EXEC1: begin
               if (r_cnt == 2'd0) begin
                  cell_en <= 1'b0;
                  r_state <= S_COMB1;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            S_COMB1: begin
`ifdef MUL_SEQ_HIGH_EN
               if (r_high) begin
                  r_mid_hi  <= w_mid[32:16];
                  r_carry   <= w_lo[32];
                  cell_src1 <= {16'h0000, cell_src1[31:16]};
                  cell_src2 <= {16'h0000, cell_src2[31:16]};
                  cell_en   <= 1'b1;
                  r_cnt     <= LAT_M1;
                  r_state   <= S_EXEC2;
               end else begin
                  rsp_result <= w_lo[31:0];
                  rsp_valid  <= 1'b1;
                  r_state    <= S_RESP;
               end
`else
               rsp_result <= w_lo[31:0];
               rsp_valid  <= 1'b1;
               r_state    <= S_RESP;
`endif
            end
`ifdef MUL_SEQ_HIGH_EN
            S_EXEC2: begin
               if (r_cnt == 2'd0) begin
                  cell_en <= 1'b0;
                  r_state <= S_COMB2;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            S_COMB2: begin
               rsp_result <= cell_p1 + {15'h0000, r_mid_hi} + {31'h0, r_carry};
               rsp_valid  <= 1'b1;
               r_state    <= S_RESP;
            end
`endif
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               cell_en   <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hello_nioii_nios2_mul_seq.sv
// Bench for hello_nioii_nios2_mul_seq: directed vector table plus backpressure and
// mid-operation reset sequences, with a one-cycle registered multiplier cell model.
module tb_hello_nioii_nios2_mul_seq;

   localparam int L = 1;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        req_high;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        busy;
   logic [31:0] cell_src1;
   logic [31:0] cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1;
   logic [31:0] cell_p2;
   logic [31:0] cell_p3;

   int total = 0;
   int bad   = 0;

   hello_nioii_nios2_mul_seq #(.CELL_LATENCY(L)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .req_high   (req_high),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .busy       (busy),
      .cell_src1  (cell_src1),
      .cell_src2  (cell_src2),
      .cell_en    (cell_en),
      .cell_p1    (cell_p1),
      .cell_p2    (cell_p2),
      .cell_p3    (cell_p3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // multiplier cell: one registered stage, cleared by reset
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cell_p1 <= 32'h0;
         cell_p2 <= 32'h0;
         cell_p3 <= 32'h0;
      end else if (cell_en) begin
         cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
         cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
         cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        hi;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
      string       nm;
   } vec_t;

   vec_t vecs[10];

`ifdef MUL_SEQ_HIGH_EN
   localparam bit HIGH_BUILT = 1'b1;
`else
   localparam bit HIGH_BUILT = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic hi,
                         input logic [31:0] exp, input string nm, input bit rdy_hi);
      int k;
      int exp_lat;
      exp_lat = (hi && HIGH_BUILT) ? 2 * L + 3 : L + 2;
      @(negedge clk);
      chk({nm, "_idle_ready"}, {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_src1  = a;
      req_src2  = b;
      req_high  = hi;
      rsp_ready = rdy_hi;
      @(negedge clk);
      req_valid = 1'b0;
      req_src1  = ~a;
      req_src2  = 32'hDEAD_BEEF;
      req_high  = ~hi;
      k = 1;
      while (!rsp_valid && k < 20) begin
         chk({nm, "_busy_ready"}, {30'h0, busy, req_ready}, 32'd2);
         @(negedge clk);
         k++;
      end
      chk({nm, "_rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
      chk({nm, "_latency"}, k, exp_lat);
      chk({nm, "_result"}, rsp_result, exp);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, "_done"}, {30'h0, rsp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_000F, 32'h0000_000F, "v3x5"};
      vecs[1] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h242D_2080, 32'h242D_2080, "vmix_lo"};
      vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h242D_2080, 32'h0B00_EA4E, "vmix_hi"};
      vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'h0000_0001, "vff_lo"};
      vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, "vff_hi"};
      vecs[5] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, "v64k_lo"};
      vecs[6] = '{32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 32'h0000_0001, "v64k_hi"};
      vecs[7] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001, 32'hFFFE_0001, "vffff_lo"};
      vecs[8] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'hFFFE_0001, 32'h0000_0000, "vffff_hi"};
      vecs[9] = '{32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0000, 32'h0000_0001, "vmsb_hi"};

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_src1  = 32'h0;
      req_src2  = 32'h0;
      req_high  = 1'b0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_valid_busy_en", {29'h0, rsp_valid, busy, cell_en}, 32'd0);
      chk("rst_result", rsp_result, 32'h0);
      chk("rst_src1", cell_src1, 32'h0);
      chk("rst_src2", cell_src2, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].hi,
                (vecs[i].hi && HIGH_BUILT) ? vecs[i].exp_hi : vecs[i].exp_lo,
                vecs[i].nm, 1'b0);
      end

      // rsp_ready held high the whole time: single-cycle response, no side effect
      run_op(32'h0001_0000, 32'h0001_0000, 1'b1, HIGH_BUILT ? 32'h1 : 32'h0, "rdy_held", 1'b1);

      // backpressure: result held, no acceptance while in RESP
      begin
         int k;
         @(negedge clk);
         req_valid = 1'b1;
         req_src1  = 32'd7;
         req_src2  = 32'd6;
         req_high  = 1'b0;
         @(negedge clk);
         req_src1  = 32'd100;
         req_src2  = 32'd100;
         k = 1;
         while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("hold_latency", k, L + 2);
         for (int i = 0; i < 4; i++) begin
            chk("hold_valid_busy", {30'h0, rsp_valid, busy}, 32'd3);
            chk("hold_result", rsp_result, 32'h0000_002A);
            chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
            @(negedge clk);
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk("hold_done", {30'h0, rsp_valid, req_ready}, 32'd1);
      end
      run_op(32'd9, 32'd11, 1'b0, 32'd99, "after_hold", 1'b0);

      // reset asserted during EXEC1
      @(negedge clk);
      req_valid = 1'b1;
      req_src1  = 32'h1234_5678;
      req_src2  = 32'h9ABC_DEF0;
      req_high  = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_en", {31'h0, cell_en}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'h0, rsp_valid}, 32'd0);
      chk("mid_rst_ready", {31'h0, req_ready}, 32'd1);
      chk("mid_rst_busy_en", {30'h0, busy, cell_en}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, HIGH_BUILT ? 32'hFFFF_FFFE : 32'h1,
             "after_rst", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
